// File: rtl/tc_pkg.sv
// Shared types and constants for the 4x4 tensor-core tile streamer and its MAC core.
package tc_pkg;

  localparam int unsigned TC_DIM        = 4;
  localparam int unsigned TC_TILE_WORDS = 16;
  localparam int unsigned TC_IN_WORDS   = 48;

  typedef enum logic [1:0] {LOAD, COMPUTE, DRAIN} tc_state_t;

  typedef logic [TC_DIM-1:0][TC_DIM-1:0][31:0] tc_tile_t;

  // TF32 keeps the FP32 sign/exponent and the top 10 mantissa bits.
  function automatic logic [31:0] tf32_trunc(input logic [31:0] x);
    return x & 32'hFFFF_E000;
  endfunction

endpackage

// File: rtl/tc_tile_stream_core.sv
// Combinational 4x4 TF32 multiply-accumulate core: D = A*B + C, FP32 accumulate.
// Truncating rounding; subnormal inputs and results flush to zero.
module TensorCoreAmpereTF32
  import tc_pkg::*;
(
  input  tc_tile_t a_i,
  input  tc_tile_t b_i,
  input  tc_tile_t c_i,
  output tc_tile_t d_o
);

  function automatic logic [31:0] fp_mul(input logic [31:0] x, input logic [31:0] y);
    logic        s;
    logic [21:0] p;
    logic [22:0] m;
    int          e;
    s = x[31] ^ y[31];
    if (x[30:23] == 8'd0 || y[30:23] == 8'd0) return {s, 31'd0};
    p = 22'({1'b1, x[22:13]}) * 22'({1'b1, y[22:13]});
    e = int'(x[30:23]) + int'(y[30:23]) - 127;
    if (p[21]) begin
      m = {p[20:0], 2'b00};
      e = e + 1;
    end else begin
      m = {p[19:0], 3'b000};
    end
    if (e <= 0) return {s, 31'd0};
    if (e >= 255) return {s, 8'hFF, 23'd0};
    return {s, e[7:0], m};
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] big;
    logic [31:0] sml;
    logic [7:0]  diff;
    logic [27:0] ma;
    logic [27:0] mb;
    logic [27:0] sum;
    int          e;
    if (x[30:23] == 8'd0) return y;
    if (y[30:23] == 8'd0) return x;
    if (x[30:0] >= y[30:0]) begin
      big = x;
      sml = y;
    end else begin
      big = y;
      sml = x;
    end
    diff = big[30:23] - sml[30:23];
    ma   = {1'b0, 1'b1, big[22:0], 3'b000};
    mb   = {1'b0, 1'b1, sml[22:0], 3'b000} >> diff;
    sum  = (big[31] == sml[31]) ? ma + mb : ma - mb;
    if (sum == 28'd0) return 32'd0;
    e = int'(big[30:23]);
    if (sum[27]) begin
      sum = sum >> 1;
      e   = e + 1;
    end
    for (int i = 0; i < 26; i++) begin
      if (!sum[26]) begin
        sum = sum << 1;
        e   = e - 1;
      end
    end
    if (e <= 0) return {big[31], 31'd0};
    if (e >= 255) return {big[31], 8'hFF, 23'd0};
    return {big[31], e[7:0], sum[25:3]};
  endfunction

  logic [31:0] acc;

  always_comb begin
    d_o = '0;
    acc = '0;
    for (int i = 0; i < TC_DIM; i++) begin
      for (int j = 0; j < TC_DIM; j++) begin
        acc = c_i[i][j];
        for (int k = 0; k < TC_DIM; k++) begin
          acc = fp_add(acc, fp_mul(tf32_trunc(a_i[i][k]), tf32_trunc(b_i[k][j])));
        end
        d_o[i][j] = acc;
      end
    end
  end

endmodule

// File: rtl/tc_tile_stream.sv
// Serial valid/ready front/back end for the 4x4 TF32 MAC core: loads A, B, C as 48 words,
// settles the core, captures D and returns it as 16 words.
module tc_tile_stream
  import tc_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        busy,
  output logic        err
);

  // Capture happens on the edge leaving the last settle cycle, so COMPUTE spans
  // SETTLE_CYCLES+1 cycles and D is first visible T+SETTLE_CYCLES+1 after the last beat.
  localparam logic [3:0] SettleLast = 4'(SETTLE_CYCLES);

  tc_state_t  state_q, state_d;
  logic [5:0] in_cnt_q, in_cnt_d;
  logic [3:0] out_cnt_q, out_cnt_d;
  logic [3:0] settle_cnt_q, settle_cnt_d;
  logic       err_q, err_d;
  tc_tile_t   a_q, b_q, c_q, res_q, d_core;
  logic       in_fire, out_fire, capture;

  assign in_ready  = (state_q == LOAD) && !rst;
  assign out_valid = (state_q == DRAIN);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign out_data  = out_valid ? res_q[out_cnt_q[3:2]][out_cnt_q[1:0]] : 32'd0;
  assign out_last  = out_valid && (out_cnt_q == 4'd15);
  assign busy      = (state_q != LOAD);
  assign err       = err_q;
  assign capture   = (state_q == COMPUTE) && (settle_cnt_q == SettleLast);

  always_comb begin
    state_d      = state_q;
    in_cnt_d     = in_cnt_q;
    out_cnt_d    = out_cnt_q;
    settle_cnt_d = settle_cnt_q;
    err_d        = err_q;
    unique case (state_q)
      LOAD: begin
        if (in_fire) begin
          in_cnt_d = in_cnt_q + 6'd1;
          // Beat count is authoritative; in_last only flags framing errors.
          if (in_last != (in_cnt_q == 6'd47)) err_d = 1'b1;
          if (in_cnt_q == 6'd47) begin
            in_cnt_d     = 6'd0;
            settle_cnt_d = 4'd0;
            state_d      = COMPUTE;
          end
        end
      end
      COMPUTE: begin
        if (capture) begin
          settle_cnt_d = 4'd0;
          state_d      = DRAIN;
        end else begin
          settle_cnt_d = settle_cnt_q + 4'd1;
        end
      end
      DRAIN: begin
        if (out_fire) begin
          out_cnt_d = out_cnt_q + 4'd1;
          if (out_cnt_q == 4'd15) state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= LOAD;
      in_cnt_q     <= 6'd0;
      out_cnt_q    <= 4'd0;
      settle_cnt_q <= 4'd0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_cnt_q     <= in_cnt_d;
      out_cnt_q    <= out_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      err_q        <= err_d;
    end
  end

  // Operand and result storage is not reset; every tile rewrites all of it.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      unique case (in_cnt_q[5:4])
        2'd0:    a_q[in_cnt_q[3:2]][in_cnt_q[1:0]] <= in_data;
        2'd1:    b_q[in_cnt_q[3:2]][in_cnt_q[1:0]] <= in_data;
        2'd2:    c_q[in_cnt_q[3:2]][in_cnt_q[1:0]] <= in_data;
        default: ;
      endcase
    end
    if (capture && !rst) res_q <= d_core;
  end

  TensorCoreAmpereTF32 u_core (
    .a_i (a_q),
    .b_i (b_q),
    .c_i (c_q),
    .d_o (d_core)
  );

endmodule

// File: tb/tb_tc_tile_stream.sv
// Directed self-checking bench for tc_tile_stream: identity, accumulate, backpressure,
// framing error, reset mid-drain and back-to-back tiles.
module tb_tc_tile_stream;
  import tc_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
  logic        err;

  int n_checks = 0;
  int n_bad    = 0;

  tc_tile_t t_zero, t_ident, t_fill1, t_fill2, t_pat, t_acc;

  always #5 clk = ~clk;

  tc_tile_stream #(.SETTLE_CYCLES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .err       (err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%08h expected=%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Starts and ends on a negedge; leaves in_valid high when drop==0.
  task automatic send_tile(input tc_tile_t ta, input tc_tile_t tb, input tc_tile_t tcm,
                           input int last_at, input bit drop);
    tc_tile_t m;
    int       guard;
    for (int i = 0; i < 48; i++) begin
      m        = (i < 16) ? ta : ((i < 32) ? tb : tcm);
      in_valid = 1'b1;
      in_data  = m[(i % 16) / 4][i % 4];
      in_last  = (i == last_at);
      guard    = 0;
      while (!in_ready && guard < 400) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 400) begin
        check_eq("in_ready_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
      if (i == last_at && last_at != 47) check_eq("err_after_bad_last", 32'(err), 32'd1);
    end
    if (drop) begin
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  // mode 0: always ready; mode 1: random ready with a 10-cycle stall at word 7.
  task automatic recv_tile(input tc_tile_t ex, input int mode, input int nbeats);
    int n, guard, hold;
    n     = 0;
    guard = 0;
    hold  = 0;
    while (n < nbeats && guard < 2000) begin
      if (mode == 1 && n == 7 && hold < 10 && out_valid) begin
        out_ready = 1'b0;
        check_eq("hold_data", out_data, ex[1][3]);
        hold++;
      end else begin
        out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      #1;
      if (out_valid && out_ready) begin
        check_eq("out_data", out_data, ex[n / 4][n % 4]);
        check_eq("out_last", 32'(out_last), 32'(n == 15));
        n++;
      end
      guard++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    if (n < nbeats) check_eq("out_beats_timeout", 32'(n), 32'(nbeats));
    if (nbeats == 16) begin
      check_eq("in_ready_after_drain", 32'(in_ready), 32'd1);
      check_eq("out_valid_after_drain", 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    t_zero = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        t_ident[i][j] = (i == j) ? 32'h3F80_0000 : 32'h0;
        t_fill1[i][j] = 32'h3F80_0000;
        t_fill2[i][j] = 32'h4000_0000;
        t_acc[i][j]   = (i == j) ? 32'h4000_0000 : 32'h3F80_0000;
        t_pat[i][j]   = {(j == 3), 8'(127 + i), 3'(j), 20'd0};
      end
    end

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_data", out_data, 32'd0);
    check_eq("rst_out_last", 32'(out_last), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    #1;
    check_eq("in_ready_after_rst", 32'(in_ready), 32'd1);
    @(negedge clk);

    // Identity: A=I, B=2.0, C=0; out_valid visible on the 4th negedge after the last beat.
    send_tile(t_ident, t_fill2, t_zero, 47, 1'b1);
    check_eq("lat_k1", 32'(out_valid), 32'd0);
    check_eq("busy_compute", 32'(busy), 32'd1);
    check_eq("in_ready_compute", 32'(in_ready), 32'd0);
    @(negedge clk);
    check_eq("lat_k2", 32'(out_valid), 32'd0);
    @(negedge clk);
    check_eq("lat_k3", 32'(out_valid), 32'd0);
    @(negedge clk);
    check_eq("lat_k4", 32'(out_valid), 32'd1);
    recv_tile(t_fill2, 0, 16);

    // Accumulate under random backpressure.
    send_tile(t_ident, t_ident, t_fill1, 47, 1'b1);
    recv_tile(t_acc, 1, 16);
    check_eq("err_clean", 32'(err), 32'd0);

    // Framing error on beat 30; tile still processed, err sticky.
    send_tile(t_ident, t_fill2, t_zero, 30, 1'b1);
    recv_tile(t_fill2, 0, 16);
    check_eq("err_sticky", 32'(err), 32'd1);

    // Reset after 5 result beats.
    send_tile(t_ident, t_pat, t_zero, 47, 1'b1);
    recv_tile(t_pat, 0, 5);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_mid_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_mid_busy", 32'(busy), 32'd0);
    check_eq("rst_mid_err", 32'(err), 32'd0);
    check_eq("rst_mid_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    check_eq("rst_mid_in_ready_low", 32'(in_ready), 32'd1);
    @(negedge clk);
    send_tile(t_ident, t_pat, t_zero, 47, 1'b1);
    recv_tile(t_pat, 0, 16);

    // Back-to-back tiles with in_valid held high.
    fork
      begin
        send_tile(t_ident, t_fill2, t_zero, 47, 1'b0);
        send_tile(t_pat, t_ident, t_zero, 47, 1'b1);
      end
      begin
        recv_tile(t_fill2, 0, 16);
        recv_tile(t_pat, 0, 16);
      end
    join
    check_eq("err_b2b", 32'(err), 32'd0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
